// File: rtl/imm_extend_pipe.sv
// Immediate extender (sign / zero / upper / branch) feeding a 2-entry output FIFO.
// Ready/valid on both sides; in_ready_o depends on registered occupancy only.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic [15:0]      done_cnt_o
);

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                                input logic [1:0]      mode);
        logic signed [OUT_W-1:0] sx;
        logic        [OUT_W-1:0] res;
        sx = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        case (mode)
            MODE_SIGN:   res = sx;
            MODE_ZERO:   res = {{(OUT_W-IN_W){1'b0}}, imm};
            MODE_UPPER:  res = {imm, {(OUT_W-IN_W){1'b0}}};
            MODE_BRANCH: res = sx <<< 2;
            default:     res = sx;
        endcase
        return res;
    endfunction

    logic [OUT_W-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [15:0]      done_cnt_q, done_cnt_d;
    logic             push, pop;

    assign in_ready_o  = (count_q < 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign push        = in_valid_i && in_ready_o && !rst_i;
    assign pop         = out_valid_o && out_ready_i;
    assign data_o      = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign done_cnt_o  = done_cnt_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        done_cnt_d = done_cnt_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d   = ~rd_ptr_q;
            done_cnt_d = done_cnt_q + 16'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state: reset wins over any same-edge transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            done_cnt_q <= 16'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    // Storage carries no reset; stale entries are masked by out_valid_o.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= extend(data_i, mode_i);
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed vectors push expected results,
// a negedge monitor pops and compares on every output transfer.
module tb_imm_extend_pipe;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [15:0] data_i = '0;
    logic [1:0]  mode_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] data_o;
    logic [15:0] done_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .data_i(data_i), .mode_i(mode_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .data_o(data_o), .done_cnt_o(done_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        exp_q.delete();
    endtask

    // Present one immediate until accepted (bounded), recording its expected result.
    task automatic send(input logic [15:0] d, input logic [1:0] m, input logic [31:0] e);
        bit done = 0;
        in_valid_i = 1'b1;
        data_i     = d;
        mode_i     = m;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                exp_q.push_back(e);
                done = 1;
            end
            step();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready_o=0 expected accept of %h", d);
        end
        in_valid_i = 1'b0;
    endtask

    // Monitor: pop on every output transfer, and idle data must read zero.
    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected no output", data_o);
            end else begin
                chk("data_o", data_o, exp_q.pop_front());
            end
        end
        if (!rst_i && !out_valid_o) chk("idle_data_zero", data_o, 32'h0);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        do_reset();
        @(negedge clk_i);
        chk("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready_o},  32'd1);
        chk("rst_done_cnt",  {16'b0, done_cnt_o},  32'd0);
        chk("rst_data",      data_o,               32'd0);
        step();

        // Mode sweep, one cycle latency.
        out_ready_i = 1'b1;
        send(16'h8004, 2'b00, 32'hFFFF8004);
        @(negedge clk_i); chk("lat_sign", {31'b0, out_valid_o}, 32'd1); step();
        send(16'h8004, 2'b01, 32'h00008004);
        @(negedge clk_i); chk("lat_zero", {31'b0, out_valid_o}, 32'd1); step();
        send(16'h8004, 2'b10, 32'h80040000);
        @(negedge clk_i); chk("lat_upper", {31'b0, out_valid_o}, 32'd1); step();
        send(16'h8004, 2'b11, 32'hFFFE0010);
        @(negedge clk_i); chk("lat_branch", {31'b0, out_valid_o}, 32'd1); step();
        send(16'h1234, 2'b11, 32'h000048D0);
        send(16'h7FFF, 2'b00, 32'h00007FFF);
        step(); step();
        chk("sweep_done_cnt", {16'b0, done_cnt_o}, 32'd6);

        // Fill and stall.
        do_reset();
        out_ready_i = 1'b0;
        send(16'h0001, 2'b00, 32'h00000001);
        send(16'h0002, 2'b00, 32'h00000002);
        @(negedge clk_i);
        chk("full_in_ready", {31'b0, in_ready_o}, 32'd0);
        step();
        in_valid_i = 1'b1; data_i = 16'h0003; mode_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("stall_in_ready", {31'b0, in_ready_o}, 32'd0);
            chk("stall_hold",     data_o,              32'h00000001);
            step();
        end
        in_valid_i = 1'b0;

        // Drain order.
        out_ready_i = 1'b1;
        step(); step();
        out_ready_i = 1'b0;
        @(negedge clk_i);
        chk("drain_out_valid", {31'b0, out_valid_o}, 32'd0);
        chk("drain_data",      data_o,               32'd0);
        chk("drain_done_cnt",  {16'b0, done_cnt_o},  32'd2);
        step();

        // Empty pop has no effect.
        out_ready_i = 1'b1; step(); out_ready_i = 1'b0;
        @(negedge clk_i);
        chk("empty_pop_cnt", {16'b0, done_cnt_o}, 32'd2);
        step();

        // Simultaneous push/pop at occupancy 1.
        send(16'h000A, 2'b01, 32'h0000000A);
        out_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid_i = 1'b1;
            data_i = 16'hF000 + 16'(k);
            mode_i = 2'b01;
            @(negedge clk_i);
            chk("pp_in_ready",  {31'b0, in_ready_o},  32'd1);
            chk("pp_out_valid", {31'b0, out_valid_o}, 32'd1);
            exp_q.push_back(32'h0000F000 + 32'(k));
            step();
        end
        in_valid_i = 1'b0;
        step(); step();
        chk("pp_done_cnt", {16'b0, done_cnt_o}, 32'd13);

        // Reset mid-operation at occupancy 2 with done_cnt 5.
        do_reset();
        out_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) send(16'h0100 + 16'(k), 2'b10, {16'h0100 + 16'(k), 16'h0});
        step(); step();
        out_ready_i = 1'b0;
        chk("pre_rst_done", {16'b0, done_cnt_o}, 32'd5);
        send(16'hAAAA, 2'b00, 32'hFFFFAAAA);
        send(16'h5555, 2'b00, 32'h00005555);
        rst_i = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b1; data_i = 16'h7777;
        step();
        rst_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        chk("mid_rst_out_valid", {31'b0, out_valid_o}, 32'd0);
        chk("mid_rst_in_ready",  {31'b0, in_ready_o},  32'd1);
        chk("mid_rst_done",      {16'b0, done_cnt_o},  32'd0);
        chk("mid_rst_data",      data_o,               32'd0);
        step();

        // Counter wrap after 65536 output transfers.
        out_ready_i = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_valid_i = 1'b1;
            data_i = 16'(i);
            mode_i = 2'b01;
            @(negedge clk_i);
            if (in_ready_o) exp_q.push_back({16'h0, 16'(i)});
            else chk("wrap_in_ready", 32'd0, 32'd1);
            step();
        end
        in_valid_i = 1'b0;
        step(); step(); step();
        chk("wrap_done_cnt", {16'b0, done_cnt_o}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
